// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock-enable divider.
//   CNT_W_DEF : default width of counter, divisor and high-time fields
//   DIV_MIN   : smallest legal divisor; smaller requests are raised to it
//   clamp_div / clamp_high : turn a requested (div, high) pair into the
//                            (div_c, high_c) pair that is actually stored
package clkdiv_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned DIV_MIN   = 2;

    // Operands are zero-extended to 32 bits by the caller. The result
    // never exceeds the wider of the input and DIV_MIN, so truncating
    // back to the field width is lossless.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'(DIV_MIN)) ? 32'(DIV_MIN) : div;
    endfunction

    // div_c must already be clamped. A high time longer than the period
    // saturates to the period, which makes q constant 1.
    function automatic logic [31:0] clamp_high(input logic [31:0] div_c,
                                               input logic [31:0] high);
        return (high > div_c) ? div_c : high;
    endfunction

endpackage

// File: rtl/clkdiv_cfg_shadow.sv
// Single-slot configuration shadow for prog_clk_divider.
//   clk, rst_n    : clock, asynchronous active-low reset
//   cfg_valid     : producer offers a new (cfg_div, cfg_high) pair
//   cfg_div       : requested period in clk cycles
//   cfg_high      : requested high cycles per period
//   cfg_ready     : slot free; transfer on cfg_valid && cfg_ready
//   apply         : strobe from the divider; shadow contents were consumed
//   pending       : shadow holds an accepted, not yet applied config
//   shadow_div    : clamped divisor waiting to be applied
//   shadow_high   : clamped high time waiting to be applied
module clkdiv_cfg_shadow
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_ready,
    input  logic             apply,
    output logic             pending,
    output logic [CNT_W-1:0] shadow_div,
    output logic [CNT_W-1:0] shadow_high
);

    logic             pending_q, pending_d;
    logic [CNT_W-1:0] shadow_div_q, shadow_div_d;
    logic [CNT_W-1:0] shadow_high_q, shadow_high_d;
    logic             accept;

    assign cfg_ready   = !pending_q;
    assign accept      = cfg_valid && !pending_q;
    assign pending     = pending_q;
    assign shadow_div  = shadow_div_q;
    assign shadow_high = shadow_high_q;

    // apply is only raised while pending is set, and accept only while it
    // is clear, so the two never meet on the same edge.
    always_comb begin
        pending_d     = pending_q;
        shadow_div_d  = shadow_div_q;
        shadow_high_d = shadow_high_q;
        if (accept) begin
            pending_d     = 1'b1;
            shadow_div_d  = CNT_W'(clamp_div(32'(cfg_div)));
            shadow_high_d = CNT_W'(clamp_high(clamp_div(32'(cfg_div)),
                                              32'(cfg_high)));
        end else if (apply) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= 1'b0;
            shadow_div_q  <= '0;
            shadow_high_q <= '0;
        end else begin
            pending_q     <= pending_d;
            shadow_div_q  <= shadow_div_d;
            shadow_high_q <= shadow_high_d;
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Runtime-programmable clock-enable divider with programmable duty cycle.
//   clk, rst_n    : clock, asynchronous active-low reset
//   ena           : count enable; low freezes counter and q, clears tick
//   cfg_valid     : new configuration offered
//   cfg_div       : requested period in clk cycles (clamped to >= 2)
//   cfg_high      : requested high cycles per period (clamped to <= div)
//   cfg_ready     : configuration slot free
//   cfg_pending   : accepted configuration not yet applied
//   q             : registered divided output
//   tick          : registered one-cycle pulse on each period start
module prog_clk_divider
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV  = 10,
    parameter int unsigned DEFAULT_HIGH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_pending,
    output logic             q,
    output logic             tick
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEFAULT_HIGH);
    // Counter sits at the last count so the first enabled edge wraps and
    // starts a period.
    localparam logic [CNT_W-1:0] CNT_RST  = CNT_W'(DEFAULT_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             q_q, q_d;
    logic             tick_q, tick_d;

    logic             pending;
    logic [CNT_W-1:0] shadow_div;
    logic [CNT_W-1:0] shadow_high;
    logic             apply;
    logic             wrap;
    logic [CNT_W-1:0] cnt_inc;

    clkdiv_cfg_shadow #(
        .CNT_W (CNT_W)
    ) u_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_high    (cfg_high),
        .cfg_ready   (cfg_ready),
        .apply       (apply),
        .pending     (pending),
        .shadow_div  (shadow_div),
        .shadow_high (shadow_high)
    );

    // div_q >= 2 always, so div_q - 1 cannot underflow.
    assign wrap    = (cnt_q == div_q - CNT_W'(1));
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        high_d = high_q;
        q_d    = q_q;
        tick_d = 1'b0;
        apply  = 1'b0;
        if (ena) begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (pending) begin
                    // New settings take effect on the first cycle of the
                    // new period, so q is judged against the new high time.
                    apply  = 1'b1;
                    div_d  = shadow_div;
                    high_d = shadow_high;
                    q_d    = (shadow_high != '0);
                end else begin
                    q_d = (high_q != '0);
                end
            end else begin
                cnt_d = cnt_inc;
                q_d   = (cnt_inc < high_q);
            end
        end else if (pending) begin
            // While frozen there is no period to protect: apply at once and
            // park the counter so the next enabled edge starts a period.
            apply  = 1'b1;
            div_d  = shadow_div;
            high_d = shadow_high;
            cnt_d  = shadow_div - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= CNT_RST;
            div_q  <= DIV_RST;
            high_q <= HIGH_RST;
            q_q    <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            high_q <= high_d;
            q_q    <= q_d;
            tick_q <= tick_d;
        end
    end

    assign q           = q_q;
    assign tick        = tick_q;
    assign cfg_pending = pending;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Scoreboard bench for prog_clk_divider: the driver pushes the expected
// post-edge {q, tick, cfg_ready, cfg_pending} for every edge it drives;
// the monitor pops one entry per edge and compares.
module tb_prog_clk_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_div = '0;
    logic [15:0] cfg_high = '0;
    logic        cfg_ready;
    logic        cfg_pending;
    logic        q;
    logic        tick;

    prog_clk_divider #(
        .CNT_W        (16),
        .DEFAULT_DIV  (10),
        .DEFAULT_HIGH (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_high    (cfg_high),
        .cfg_ready   (cfg_ready),
        .cfg_pending (cfg_pending),
        .q           (q),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          q;
        bit          tick;
        bit          rdy;
        bit          pend;
        int unsigned idx;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned edge_idx = 0;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    // One clock edge: set inputs on the falling edge, record what the
    // outputs must read after the next rising edge.
    task automatic drive(input bit e, input bit v, input logic [15:0] d,
                         input logic [15:0] h, input bit xq, input bit xt,
                         input bit xr, input bit xp);
        exp_t x;
        @(negedge clk);
        ena       = e;
        cfg_valid = v;
        cfg_div   = d;
        cfg_high  = h;
        x.q = xq; x.tick = xt; x.rdy = xr; x.pend = xp; x.idx = edge_idx;
        sb.push_back(x);
        edge_idx++;
    endtask

    // n enabled edges of a D-cycle period with H high cycles, starting at
    // period phase k0: q high for phases 0..H-1, tick at phase 0.
    task automatic run(input int d, input int h, input int k0, input int n,
                       input bit xr, input bit xp);
        for (int i = 0; i < n; i++) begin
            int k;
            k = (k0 + i) % d;
            drive(1'b1, 1'b0, '0, '0, k < h, k == 0, xr, xp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if ({q, tick, cfg_ready, cfg_pending} !== {e.q, e.tick, e.rdy, e.pend}) begin
                n_fail++;
                $display("FAIL edge%0d q/tick/ready/pending: got %b%b%b%b want %b%b%b%b",
                         e.idx, q, tick, cfg_ready, cfg_pending,
                         e.q, e.tick, e.rdy, e.pend);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #2;
        chk("reset_q", q, 1'b0);
        chk("reset_tick", tick, 1'b0);
        chk("reset_ready", cfg_ready, 1'b1);
        chk("reset_pending", cfg_pending, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: defaults, 5 high / 5 low, tick every 10
        run(10, 5, 0, 20, 1'b1, 1'b0);

        // 2: mid-period reload to 7/2; old period finishes first
        run(10, 5, 0, 3, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 16'd7, 16'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        run(10, 5, 4, 6, 1'b0, 1'b1);
        run(7, 2, 0, 14, 1'b1, 1'b0);

        // 3: div=1/high=9 clamps to 2/2 (q stuck 1), then high=0 (q stuck 0)
        run(7, 2, 0, 1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 16'd1, 16'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        run(7, 2, 2, 5, 1'b0, 1'b1);
        run(2, 2, 0, 6, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 16'd2, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        run(2, 2, 1, 1, 1'b0, 1'b1);
        run(2, 0, 0, 6, 1'b1, 1'b0);

        // 4: move to 6/3, freeze with q high, reload 4/3 while frozen
        drive(1'b1, 1'b1, 16'd6, 16'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        run(2, 0, 1, 1, 1'b0, 1'b1);
        run(6, 3, 0, 2, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 16'd4, 16'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        run(4, 3, 0, 8, 1'b1, 1'b0);

        // 5: second request held while pending is ignored, then accepted
        drive(1'b1, 1'b1, 16'd5, 16'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 16'd8, 16'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 16'd8, 16'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 16'd8, 16'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 16'd8, 16'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 16'd8, 16'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        run(5, 1, 2, 3, 1'b0, 1'b1);
        run(8, 4, 0, 8, 1'b1, 1'b0);

        // 6: async reset mid-period with a pending config
        run(8, 4, 0, 3, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 16'd3, 16'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst_n     = 1'b0;
        ena       = 1'b0;
        cfg_valid = 1'b0;
        #1;
        chk("async_rst_q", q, 1'b0);
        chk("async_rst_tick", tick, 1'b0);
        chk("async_rst_pending", cfg_pending, 1'b0);
        chk("async_rst_ready", cfg_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        run(10, 5, 0, 12, 1'b1, 1'b0);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size() == 0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
